clock_divider_gen: RTL and testbench

//  Synthesisable, parametrised successor to the behavioural clock generator.

---
 rtl/clock_pkg.sv | 25 ++
 rtl/clock_half_counter.sv | 44 ++++
 rtl/clock_divider_gen.sv | 159 +++++++++++++++
 tb/tb_clock_divider_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and helpers for the divided clock generator
//
// Purpose : phase-state encoding, minimum half-period and the divisor clamp
//           used by clock_divider_gen and clock_half_counter.
// Contents: clk_state_t  IDLE / HIGH / LOW phase of the divided clock
//           MIN_HALF     shortest legal phase length in system clock cycles
//           clamp_half   maps a programmed divisor onto a legal half-period

package clock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } clk_state_t;

  localparam int unsigned MIN_HALF = 1;

  // A divisor of zero would mean a zero-length phase; run it as the
  // shortest phase instead so the output still toggles.
  function automatic int unsigned clamp_half(input int unsigned divisor);
    return (divisor < MIN_HALF) ? MIN_HALF : divisor;
  endfunction

endpackage

// File: rtl/clock_half_counter.sv
// rtl/clock_half_counter.sv - down-counter timing one phase of the divided clock
//
// Purpose : loaded with the half-period on entry to a phase, counts down once
//           per system clock and flags the last cycle of the phase.
// Ports   : i_clock   system clock
//           i_reset   synchronous active-high reset, clears the count
//           i_load    load i_half (entry into HIGH or LOW)
//           i_clear   force the count to zero (entry into IDLE)
//           i_half    phase length in system clock cycles, already clamped >= 1
//           o_expire  high during the last cycle of the current phase

module clock_half_counter
  import clock_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic                 i_clear,
  input  logic [DIV_WIDTH-1:0] i_half,
  output logic                 o_expire
);

  logic [DIV_WIDTH-1:0] count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_half;
    end else if (count != '0) begin
      count <= count - DIV_WIDTH'(1);
    end
  end

  // The count equals the number of cycles left in the phase including the
  // current one, so the phase ends while it reads MIN_HALF. An idle counter
  // sits at zero and never expires.
  assign o_expire = (count == DIV_WIDTH'(MIN_HALF));

endmodule

// File: rtl/clock_divider_gen.sv
// rtl/clock_divider_gen.sv - programmable divided clock with run/halt and single-step
//
// Purpose : derives a registered, glitch-free divided clock from i_clock.
//           Continuous mode runs while i_enable is high; single-step mode
//           emits exactly one full period per rising edge of i_step. Start and
//           stop are decided only at the end of a low phase, so no phase is
//           ever shortened. Also provides edge strobes and a rise counter.
// Ports   : i_clock      system clock, all logic on its rising edge
//           i_reset      synchronous active-high reset
//           i_enable     run request in continuous mode
//           i_step_mode  1 = single-step mode, 0 = continuous mode
//           i_step       step request, rising edge counts
//           i_divisor    half-period in i_clock cycles, 0 treated as 1
//           o_clock      divided clock
//           o_rise       one-cycle strobe in the first cycle o_clock is 1
//           o_fall       one-cycle strobe in the first cycle o_clock is 0 after high
//           o_running    high while the generator is not idle
//           o_cycles     count of o_clock rising edges since reset, wraps

module clock_divider_gen
  import clock_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_step_mode,
  input  logic                   i_step,
  input  logic [DIV_WIDTH-1:0]   i_divisor,
  output logic                   o_clock,
  output logic                   o_rise,
  output logic                   o_fall,
  output logic                   o_running,
  output logic [COUNT_WIDTH-1:0] o_cycles
);

  clk_state_t           state;
  clk_state_t           state_next;
  logic [DIV_WIDTH-1:0] half;
  logic                 load;
  logic                 clear;
  logic                 expire;
  logic                 step_q;
  logic                 step_edge;
  logic                 step_pending;
  logic                 step_pending_next;
  logic                 run_req;
  logic                 go;
  logic                 enter_high;
  logic                 enter_low;

  assign half = DIV_WIDTH'(clamp_half(32'(i_divisor)));

  clock_half_counter #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_half_counter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (load),
    .i_clear  (clear),
    .i_half   (half),
    .o_expire (expire)
  );

  // Step edges only count in step mode; in continuous mode they are
  // discarded rather than remembered for later.
  assign step_edge = i_step && !step_q && i_step_mode;
  assign run_req   = !i_step_mode && i_enable;
  assign go        = run_req || step_pending;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_next = HIGH;
          load       = 1'b1;
        end
      end
      HIGH: begin
        if (expire) begin
          state_next = LOW;
          load       = 1'b1;
        end
      end
      LOW: begin
        // The only point where running or stopping is decided.
        if (expire) begin
          if (go) begin
            state_next = HIGH;
            load       = 1'b1;
          end else begin
            state_next = IDLE;
            clear      = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        clear      = 1'b1;
      end
    endcase
  end

  assign enter_high = (state != HIGH) && (state_next == HIGH);
  assign enter_low  = (state == HIGH) && (state_next == LOW);

  // A pending step is consumed by the period it starts. An edge arriving in
  // that same cycle re-arms it; an edge arriving while already armed is lost.
  always_comb begin
    step_pending_next = step_pending || step_edge;
    if (enter_high) begin
      step_pending_next = step_edge;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      step_q       <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      step_q       <= i_step;
      step_pending <= step_pending_next;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register and carry no combinational decode.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_clock   <= 1'b0;
      o_rise    <= 1'b0;
      o_fall    <= 1'b0;
      o_running <= 1'b0;
      o_cycles  <= '0;
    end else begin
      o_clock   <= (state_next == HIGH);
      o_rise    <= enter_high;
      o_fall    <= enter_low;
      o_running <= (state_next != IDLE);
      if (enter_high) begin
        o_cycles <= o_cycles + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_gen.sv
// tb/tb_clock_divider_gen.sv - scoreboard bench for clock_divider_gen

module tb_clock_divider_gen;

  localparam int DIV_WIDTH   = 8;
  localparam int COUNT_WIDTH = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic                   step_mode;
  logic                   step;
  logic [DIV_WIDTH-1:0]   divisor;
  logic                   div_clock;
  logic                   rise;
  logic                   fall;
  logic                   running;
  logic [COUNT_WIDTH-1:0] cycles;

  typedef struct {
    string       tag;
    logic        clk_v;
    logic        rise;
    logic        fall;
    logic        running;
    logic [31:0] cycles;
  } exp_t;

  exp_t  exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    exp_cycles  = 0;
  string cur_test    = "init";

  clock_divider_gen #(
    .DIV_WIDTH   (DIV_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) dut (
    .i_clock     (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_step_mode (step_mode),
    .i_step      (step),
    .i_divisor   (divisor),
    .o_clock     (div_clock),
    .o_rise      (rise),
    .o_fall      (fall),
    .o_running   (running),
    .o_cycles    (cycles)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_entry(input logic c, input logic r, input logic f, input logic run);
    exp_t e;
    e.tag     = cur_test;
    e.clk_v   = c;
    e.rise    = r;
    e.fall    = f;
    e.running = run;
    e.cycles  = 32'(exp_cycles);
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_entry(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_period(input int hi, input int lo);
    exp_cycles++;
    for (int i = 0; i < hi; i++) push_entry(1'b1, i == 0, 1'b0, 1'b1);
    for (int i = 0; i < lo; i++) push_entry(1'b0, 1'b0, i == 0, 1'b1);
  endtask

  // Each cycle: let the edge happen, then compare the outputs it produced
  // against the next scoreboard entry.
  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check_vec({cur_test, " sb underrun"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_vec({e.tag, " o_clock"},   32'(div_clock), 32'(e.clk_v));
        check_vec({e.tag, " o_rise"},    32'(rise),      32'(e.rise));
        check_vec({e.tag, " o_fall"},    32'(fall),      32'(e.fall));
        check_vec({e.tag, " o_running"}, 32'(running),   32'(e.running));
        check_vec({e.tag, " o_cycles"},  cycles,         e.cycles);
      end
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    exp_cycles = 0;
    push_idle(2);
    run_cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    divisor   = '0;

    cur_test = "reset";
    push_idle(2);
    run_cycles(2);

    cur_test = "div3_run";
    reset   = 1'b0;
    enable  = 1'b1;
    divisor = 8'd3;
    for (int p = 0; p < 4; p++) push_period(3, 3);
    run_cycles(24);
    enable = 1'b0;
    push_idle(2);
    run_cycles(2);

    cur_test = "div0";
    enable  = 1'b1;
    divisor = 8'd0;
    for (int p = 0; p < 3; p++) push_period(1, 1);
    run_cycles(6);
    enable = 1'b0;
    push_idle(2);
    run_cycles(2);

    cur_test = "drop_enable";
    enable  = 1'b1;
    divisor = 8'd4;
    push_period(4, 4);
    push_idle(2);
    run_cycles(1);
    enable = 1'b0;
    run_cycles(9);

    cur_test  = "step3";
    step_mode = 1'b1;
    enable    = 1'b1;
    divisor   = 8'd2;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      push_idle(1);
      push_period(2, 2);
      push_idle(5);
      run_cycles(1);
      step = 1'b0;
      run_cycles(9);
    end

    cur_test = "step_dup";
    divisor  = 8'd3;
    step     = 1'b1;
    push_idle(1);
    push_period(3, 3);
    push_period(3, 3);
    push_idle(3);
    run_cycles(1);
    step = 1'b0;
    run_cycles(1);
    step = 1'b1;
    run_cycles(1);
    step = 1'b0;
    run_cycles(1);
    step = 1'b1;
    run_cycles(1);
    step = 1'b0;
    run_cycles(11);

    cur_test = "div_change";
    divisor  = 8'd2;
    step     = 1'b1;
    push_idle(1);
    push_period(2, 5);
    push_idle(2);
    run_cycles(1);
    step = 1'b0;
    run_cycles(1);
    divisor = 8'd5;
    run_cycles(8);

    cur_test  = "step_in_cont";
    step_mode = 1'b0;
    enable    = 1'b0;
    step      = 1'b1;
    push_idle(5);
    run_cycles(1);
    step = 1'b0;
    run_cycles(1);
    step_mode = 1'b1;
    run_cycles(3);

    cur_test  = "reset_mid_high";
    step_mode = 1'b0;
    enable    = 1'b1;
    divisor   = 8'd4;
    exp_cycles++;
    push_entry(1'b1, 1'b1, 1'b0, 1'b1);
    push_entry(1'b1, 1'b0, 1'b0, 1'b1);
    run_cycles(2);
    do_reset();
    cur_test = "after_reset";
    divisor  = 8'd2;
    push_period(2, 2);
    run_cycles(3);
    enable = 1'b0;
    run_cycles(1);
    push_idle(2);
    run_cycles(2);

    check_vec("sb drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
